uart_tx: RTL and testbench

//  Serial UART transmitter, 8 data bits, LSB first, idle-high line, optional parity,
//  1 or 2 stop bits. Accepts bytes over a valid/ready handshake into a one-deep

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// A one-deep holding register lets consecutive frames leave with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 118,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_tx_valid,
    input  logic [7:0] in_tx_data,
    output logic       out_tx_ready,
    output logic       out_tx,
    output logic       out_tx_busy,
    output logic       out_tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_tx: CLKS_PER_BIT must be at least 4");
    end

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             ready_q, ready_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             baud_end;
    logic             load;
    logic             accept;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    stop_d  = 1'b0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        done_d = 1'b1;
                        stop_d = 1'b0;
                        // Chain straight into the next start bit when a byte is waiting.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            shift_d = hold_data_q;
            par_d   = (PARITY == 2) ? ~^hold_data_q : ^hold_data_q;
        end
    end

    always_comb begin
        accept      = in_tx_valid & ready_q;
        hold_full_d = (hold_full_q & ~load) | accept;
        hold_data_d = accept ? in_tx_data : hold_data_q;
        // NOTE: ready is registered from the next-state hold flag, so it never
        // depends combinationally on in_tx_valid yet still tracks load/accept exactly.
        ready_d     = ~hold_full_d;

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            ready_q     <= 1'b1;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign out_tx_ready = ready_q;
    assign out_tx       = tx_q;
    assign out_tx_busy  = (state_q != S_IDLE);
    assign out_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations behind one observation mux,
// a queue-driven byte driver, and per-feature test tasks with inline comparisons.
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        bit         pulse;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic       drv_valid;
    logic [7:0] drv_data;
    logic [3:0] tx_w, rdy_w, busy_w, done_w;
    logic       obs_tx, obs_ready, obs_busy, obs_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gap_max = 0;
    int gap_left = 0;
    int ign_cnt = 0;
    int xfer_cyc = 0;

    item_t      drv_q[$];
    logic [7:0] acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx u_8n1 (
        .in_clk(clk), .in_rst(rst_n),
        .in_tx_valid(drv_valid && sel == 2'd0), .in_tx_data(drv_data),
        .out_tx_ready(rdy_w[0]), .out_tx(tx_w[0]), .out_tx_busy(busy_w[0]), .out_tx_done(done_w[0])
    );
    uart_tx #(.PARITY(1)) u_even (
        .in_clk(clk), .in_rst(rst_n),
        .in_tx_valid(drv_valid && sel == 2'd1), .in_tx_data(drv_data),
        .out_tx_ready(rdy_w[1]), .out_tx(tx_w[1]), .out_tx_busy(busy_w[1]), .out_tx_done(done_w[1])
    );
    uart_tx #(.PARITY(2)) u_odd (
        .in_clk(clk), .in_rst(rst_n),
        .in_tx_valid(drv_valid && sel == 2'd2), .in_tx_data(drv_data),
        .out_tx_ready(rdy_w[2]), .out_tx(tx_w[2]), .out_tx_busy(busy_w[2]), .out_tx_done(done_w[2])
    );
    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_fast (
        .in_clk(clk), .in_rst(rst_n),
        .in_tx_valid(drv_valid && sel == 2'd3), .in_tx_data(drv_data),
        .out_tx_ready(rdy_w[3]), .out_tx(tx_w[3]), .out_tx_busy(busy_w[3]), .out_tx_done(done_w[3])
    );

    assign obs_tx    = tx_w[sel];
    assign obs_ready = rdy_w[sel];
    assign obs_busy  = busy_w[sel];
    assign obs_done  = done_w[sel];

    // Driver: decides at each falling edge whether the next rising edge transfers.
    initial begin
        drv_valid = 1'b0;
        drv_data  = '0;
        forever begin
            @(negedge clk);
            if (gap_left > 0) begin
                gap_left--;
                drv_valid = 1'b0;
            end else if (drv_q.size() > 0) begin
                drv_valid = 1'b1;
                drv_data  = drv_q[0].data;
                if (obs_ready === 1'b1) begin
                    acc_q.push_back(drv_q[0].data);
                    xfer_cyc = cyc + 1;
                    void'(drv_q.pop_front());
                    gap_left = int'($urandom_range(32'(gap_max), 0));
                end else if (drv_q[0].pulse) begin
                    ign_cnt++;
                    void'(drv_q.pop_front());
                end
            end else begin
                drv_valid = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, input bit p);
        item_t it;
        it.data  = d;
        it.pulse = p;
        drv_q.push_back(it);
    endtask

    // Waits for a start bit, then records one sample per bit and per-cycle properties.
    task automatic capture(input int cpb, input int nbits,
                           output logic [11:0] bits, output bit got, output bit stable,
                           output bit busy_ok, output bit done_early,
                           output logic done_after, output logic rdy_mid, output int t0);
        int idx;
        bits = '0; got = 1'b0; stable = 1'b1; busy_ok = 1'b1; done_early = 1'b0;
        done_after = 1'b0; rdy_mid = 1'bx; t0 = 0;
        for (int t = 0; t < 4000; t++) begin
            if (obs_tx === 1'b0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) return;
        t0 = cyc;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < cpb; k++) begin
                idx = b * cpb + k;
                if (k == 0) bits[b] = obs_tx;
                else if (obs_tx !== bits[b]) stable = 1'b0;
                if (obs_busy !== 1'b1) busy_ok = 1'b0;
                if (idx != 0 && obs_done !== 1'b0) done_early = 1'b1;
                if (idx == (nbits * cpb) / 2) rdy_mid = obs_ready;
                @(negedge clk);
            end
        end
        done_after = obs_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            total++;
            if ({obs_tx, obs_ready, obs_busy, obs_done} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_state sel=%0d: got tx/rdy/busy/done=%b want=1100", s,
                         {obs_tx, obs_ready, obs_busy, obs_done});
            end
        end
        sel = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_basic_8n1();
        logic [11:0] bits;
        bit got, stable, busy_ok, done_early;
        logic done_after, rdy_mid;
        int t0;
        sel = 2'd0;
        push(8'h55, 1'b0);
        capture(118, 10, bits, got, stable, busy_ok, done_early, done_after, rdy_mid, t0);
        total++;
        if (!got || bits !== 12'h2AA) begin
            bad++;
            $display("FAIL 8n1_bits: got=%h want=2aa (started=%0d)", bits, got);
        end
        total++;
        if (t0 !== xfer_cyc + 1) begin
            bad++;
            $display("FAIL 8n1_latency: start at cycle %0d want %0d", t0, xfer_cyc + 1);
        end
        total++;
        if (!stable || !busy_ok || done_early) begin
            bad++;
            $display("FAIL 8n1_timing: stable=%0d busy_ok=%0d done_early=%0d want 1/1/0",
                     stable, busy_ok, done_early);
        end
        total++;
        if (done_after !== 1'b1 || obs_busy !== 1'b0 || obs_tx !== 1'b1) begin
            bad++;
            $display("FAIL 8n1_end: done=%b busy=%b tx=%b want 1/0/1", done_after, obs_busy, obs_tx);
        end
        total++;
        if (rdy_mid !== 1'b1) begin
            bad++;
            $display("FAIL 8n1_ready_mid: got=%b want=1", rdy_mid);
        end
        @(negedge clk);
        total++;
        if (obs_done !== 1'b0 || obs_tx !== 1'b1) begin
            bad++;
            $display("FAIL 8n1_done_width: done=%b tx=%b want 0/1", obs_done, obs_tx);
        end
    endtask

    task automatic test_parity();
        logic [11:0] bits, want;
        bit got, stable, busy_ok, done_early;
        logic done_after, rdy_mid;
        int t0;
        for (int p = 1; p <= 2; p++) begin
            sel  = 2'(p);
            want = (p == 1) ? 12'h60E : 12'h40E;
            push(8'h07, 1'b0);
            capture(118, 11, bits, got, stable, busy_ok, done_early, done_after, rdy_mid, t0);
            total++;
            if (!got || bits !== want) begin
                bad++;
                $display("FAIL parity%0d_bits: got=%h want=%h", p, bits, want);
            end
            total++;
            if (!stable || !busy_ok || done_early || done_after !== 1'b1) begin
                bad++;
                $display("FAIL parity%0d_length: stable=%0d busy=%0d early=%0d done=%b want 1/1/0/1",
                         p, stable, busy_ok, done_early, done_after);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [11:0] b1, b2;
        bit g1, g2, s1, s2, bz1, bz2, e1, e2;
        logic d1, d2, r1, r2;
        int t1, t2;
        sel = 2'd0;
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b0);
        capture(118, 10, b1, g1, s1, bz1, e1, d1, r1, t1);
        capture(118, 10, b2, g2, s2, bz2, e2, d2, r2, t2);
        total++;
        if (!g1 || b1 !== 12'h34A) begin
            bad++;
            $display("FAIL b2b_first_bits: got=%h want=34a", b1);
        end
        total++;
        if (!g2 || b2 !== 12'h278) begin
            bad++;
            $display("FAIL b2b_second_bits: got=%h want=278", b2);
        end
        total++;
        if (t2 - t1 !== 1180) begin
            bad++;
            $display("FAIL b2b_gap: start spacing=%0d want=1180", t2 - t1);
        end
        total++;
        if (r1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_drop: ready mid-frame=%b want=0", r1);
        end
        total++;
        if (!bz1 || !bz2 || e1 || e2 || d1 !== 1'b1 || d2 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_busy_done: busy=%0d%0d early=%0d%0d done=%b%b want 11/00/11",
                     bz1, bz2, e1, e2, d1, d2);
        end
        @(negedge clk);
    endtask

    task automatic test_two_stop();
        logic [11:0] b1, b2;
        bit g1, g2, s1, s2, bz1, bz2, e1, e2;
        logic d1, d2, r1, r2;
        int t1, t2;
        sel = 2'd3;
        push(8'hFF, 1'b0);
        push(8'hFF, 1'b0);
        capture(4, 11, b1, g1, s1, bz1, e1, d1, r1, t1);
        capture(4, 11, b2, g2, s2, bz2, e2, d2, r2, t2);
        total++;
        if (!g1 || !g2 || b1 !== 12'h7FE || b2 !== 12'h7FE || !s1 || !s2) begin
            bad++;
            $display("FAIL two_stop_bits: got=%h/%h stable=%0d%0d want=7fe/7fe stable=11",
                     b1, b2, s1, s2);
        end
        total++;
        if (t2 - t1 !== 44) begin
            bad++;
            $display("FAIL two_stop_spacing: got=%0d want=44", t2 - t1);
        end
        total++;
        if (d1 !== 1'b1 || d2 !== 1'b1) begin
            bad++;
            $display("FAIL two_stop_done: got=%b%b want=11", d1, d2);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit quiet;
        bit started;
        sel = 2'd0;
        acc_q.delete();
        push(8'h81, 1'b0);
        push(8'h42, 1'b0);
        started = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (obs_tx === 1'b0) begin
                started = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3 * 118) @(negedge clk);
        total++;
        if (!started || obs_ready !== 1'b0 || obs_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: started=%0d ready=%b busy=%b want 1/0/1",
                     started, obs_ready, obs_busy);
        end
        #2;
        drv_q.delete();
        rst_n = 1'b0;
        #1;
        total++;
        if ({obs_tx, obs_ready, obs_busy, obs_done} !== 4'b1100) begin
            bad++;
            $display("FAIL abort_async: got tx/rdy/busy/done=%b want=1100",
                     {obs_tx, obs_ready, obs_busy, obs_done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        quiet = 1'b1;
        repeat (1300) begin
            @(negedge clk);
            if (obs_tx !== 1'b1 || obs_done !== 1'b0 || obs_busy !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL abort_after: line active after reset release, got=active want=idle");
        end
    endtask

    task automatic test_ignore_and_random();
        logic [11:0] bits;
        bit got, stable, busy_ok, done_early;
        logic done_after, rdy_mid;
        logic [7:0] want_q[$];
        logic [7:0] exp;
        int t0;
        bit quiet;
        sel = 2'd3;
        gap_max = 0;
        ign_cnt = 0;
        acc_q.delete();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'hEE, 1'b1);
        want_q.push_back(8'h11);
        want_q.push_back(8'h22);
        for (int i = 0; i < 2; i++) begin
            capture(4, 11, bits, got, stable, busy_ok, done_early, done_after, rdy_mid, t0);
            total++;
            if (!got || bits[8:1] !== want_q[i] || bits[0] !== 1'b0 || bits[10:9] !== 2'b11) begin
                bad++;
                $display("FAIL ignore_frame%0d: got=%h want=%h", i, bits[8:1], want_q[i]);
            end
        end
        total++;
        if (ign_cnt !== 1 || acc_q.size() !== 2) begin
            bad++;
            $display("FAIL ignore_pulse: ignored=%0d accepted=%0d want 1/2", ign_cnt, acc_q.size());
        end
        quiet = 1'b1;
        repeat (200) begin
            if (obs_tx !== 1'b1) quiet = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL ignore_extra_frame: got=frame want=idle");
        end

        acc_q.delete();
        gap_max = 60;
        for (int i = 0; i < 200; i++) push(8'($urandom_range(255, 0)), 1'b0);
        for (int i = 0; i < 200; i++) begin
            capture(4, 11, bits, got, stable, busy_ok, done_early, done_after, rdy_mid, t0);
            total++;
            if (!got) begin
                bad++;
                $display("FAIL random_timeout: frame %0d got=none want=frame", i);
                break;
            end
            exp = (acc_q.size() > 0) ? acc_q.pop_front() : 8'hxx;
            if (bits[8:1] !== exp || bits[0] !== 1'b0 || bits[10:9] !== 2'b11 || !stable
                || done_after !== 1'b1) begin
                bad++;
                $display("FAIL random_frame%0d: got=%h frame=%h want=%h", i, bits[8:1], bits, exp);
            end
        end
        total++;
        if (acc_q.size() !== 0 || drv_q.size() !== 0) begin
            bad++;
            $display("FAIL random_leftover: pending=%0d queued=%0d want 0/0", acc_q.size(), drv_q.size());
        end
        gap_max = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 2'd0;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_two_stop();
        test_reset_abort();
        test_ignore_and_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
